// File: rtl/dsp_frame_scheduler.sv
// Frame sequencer for a fixed-length DSP program: latches a frame, starts the core, waits program + drain, captures results.
// Optional DSP_FRAME_COUNTER_EN adds a 32-bit wrapping count of completed frames on frame_count.
module dsp_frame_scheduler #(
    parameter int PROGRAM_LEN = 512,
    parameter int PIPE_DEPTH  = 4,
    parameter int DWW         = 36,
    parameter int PAW         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_strobe,
    input  logic [7:0][DWW-1:0] frame_in,
    output logic [7:0][DWW-1:0] dsp_inputs,
    output logic                dsp_start,
    input  logic [7:0][DWW-1:0] dsp_outputs,
    output logic [7:0][DWW-1:0] frame_out,
    output logic                frame_out_valid,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clear,
    input  logic                host_wr_valid,
    output logic                host_wr_ready,
    input  logic [PAW-1:0]      host_wr_addr,
    input  logic [DWW-1:0]      host_wr_data,
    output logic                pmem_wr_en,
    output logic [PAW-1:0]      pmem_wr_addr,
    output logic [DWW-1:0]      pmem_wr_data
`ifdef DSP_FRAME_COUNTER_EN
    ,
    output logic [31:0]         frame_count
`endif
);

    localparam int CNT_MAX = (PROGRAM_LEN > PIPE_DEPTH) ? PROGRAM_LEN : PIPE_DEPTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RUN_LAST_CNT   = CW'(PROGRAM_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST_CNT = (PIPE_DEPTH > 0) ? CW'(PIPE_DEPTH - 1) : '0;

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            run_last, drain_last, frame_done, capture_in;
    logic            frame_out_valid_reg, overrun_reg;
    logic [7:0][DWW-1:0] dsp_inputs_reg, frame_out_reg;

    assign run_last   = (state_reg == RUN) && (cnt_reg == RUN_LAST_CNT);
    assign drain_last = (state_reg == DRAIN) && (cnt_reg == DRAIN_LAST_CNT);
    assign frame_done = (PIPE_DEPTH == 0) ? run_last : drain_last;
    assign capture_in = (state_reg == IDLE) && sample_strobe;

    // State register and phase counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (sample_strobe) state_next = START;
            START:   state_next = RUN;
            RUN:     if (run_last) state_next = (PIPE_DEPTH == 0) ? IDLE : DRAIN;
            DRAIN:   if (drain_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts at zero on every state change so RUN and DRAIN share it
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg)
            cnt_next = '0;
        else if (state_reg == RUN || state_reg == DRAIN)
            cnt_next = cnt_reg + 1'b1;
    end

    always_comb begin
        dsp_start     = 1'b0;
        busy          = 1'b1;
        host_wr_ready = 1'b0;
        unique case (state_reg)
            IDLE: begin
                busy          = 1'b0;
                host_wr_ready = !sample_strobe && !reset;
            end
            START:   dsp_start = 1'b1;
            default: ;
        endcase
    end

    assign pmem_wr_en   = host_wr_valid && host_wr_ready;
    assign pmem_wr_addr = host_wr_addr;
    assign pmem_wr_data = host_wr_data;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (reset) begin
                    dsp_inputs_reg[gi] <= '0;
                    frame_out_reg[gi]  <= '0;
                end else begin
                    if (capture_in) dsp_inputs_reg[gi] <= frame_in[gi];
                    if (frame_done) frame_out_reg[gi]  <= dsp_outputs[gi];
                end
            end
        end
    endgenerate

    // A strobe landing on a busy frame sets overrun even if clear is asserted too
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_out_valid_reg <= 1'b0;
            overrun_reg         <= 1'b0;
        end else begin
            frame_out_valid_reg <= frame_done;
            if (sample_strobe && busy)
                overrun_reg <= 1'b1;
            else if (overrun_clear)
                overrun_reg <= 1'b0;
        end
    end

    assign dsp_inputs      = dsp_inputs_reg;
    assign frame_out       = frame_out_reg;
    assign frame_out_valid = frame_out_valid_reg;
    assign overrun         = overrun_reg;

`ifdef DSP_FRAME_COUNTER_EN
    logic [31:0] frame_count_reg;

    always_ff @(posedge clk) begin
        if (reset)
            frame_count_reg <= '0;
        else if (frame_out_valid_reg)
            frame_count_reg <= frame_count_reg + 32'd1;
    end

    assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_dsp_frame_scheduler.sv
// Bench for dsp_frame_scheduler: directed frame scenarios plus random traffic,
// checked each cycle against a cycle-arithmetic model of the frame timeline.
module tb_dsp_frame_scheduler;

    localparam int PL  = 512;
    localparam int PD  = 4;
    localparam int DWW = 36;
    localparam int PAW = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sample_strobe = 1'b0;
    logic [7:0][DWW-1:0] frame_in = '0;
    logic [7:0][DWW-1:0] dsp_inputs;
    logic                dsp_start;
    logic [7:0][DWW-1:0] dsp_outputs = '0;
    logic [7:0][DWW-1:0] frame_out;
    logic                frame_out_valid;
    logic                busy;
    logic                overrun;
    logic                overrun_clear = 1'b0;
    logic                host_wr_valid = 1'b0;
    logic                host_wr_ready;
    logic [PAW-1:0]      host_wr_addr = '0;
    logic [DWW-1:0]      host_wr_data = '0;
    logic                pmem_wr_en;
    logic [PAW-1:0]      pmem_wr_addr;
    logic [DWW-1:0]      pmem_wr_data;
`ifdef DSP_FRAME_COUNTER_EN
    logic [31:0]         frame_count;
`endif

    dsp_frame_scheduler #(
        .PROGRAM_LEN(PL), .PIPE_DEPTH(PD), .DWW(DWW), .PAW(PAW)
    ) dut (
        .clk(clk), .reset(reset),
        .sample_strobe(sample_strobe), .frame_in(frame_in),
        .dsp_inputs(dsp_inputs), .dsp_start(dsp_start),
        .dsp_outputs(dsp_outputs), .frame_out(frame_out),
        .frame_out_valid(frame_out_valid), .busy(busy),
        .overrun(overrun), .overrun_clear(overrun_clear),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .pmem_wr_en(pmem_wr_en), .pmem_wr_addr(pmem_wr_addr),
        .pmem_wr_data(pmem_wr_data)
`ifdef DSP_FRAME_COUNTER_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int frames_seen = 0;

    // Model: a frame accepted at cycle m_start is busy for cycles m_start+1 .. m_start+1+PL+PD
    int                  m_start = -1;
    int                  m_valid_cyc = -1;
    logic                m_ovr = 1'b0;
    logic [7:0][DWW-1:0] m_inputs = '0;
    logic [7:0][DWW-1:0] m_frame_out = '0;
    logic [31:0]         m_count = '0;
    logic                wr_done = 1'b0;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic rand_frame(output logic [7:0][DWW-1:0] f);
        for (int i = 0; i < 8; i++) f[i] = DWW'({$urandom(), $urandom()});
    endtask

    task automatic step();
        logic exp_busy, exp_ready, exp_wen, exp_valid;
        rand_frame(frame_in);
        rand_frame(dsp_outputs);
        @(negedge clk);
        exp_busy  = (m_start >= 0) && (cyc >= m_start + 1) && (cyc <= m_start + 1 + PL + PD);
        exp_ready = !reset && !exp_busy && !sample_strobe;
        exp_wen   = host_wr_valid && exp_ready;
        exp_valid = (cyc == m_valid_cyc);
        chk("dsp_start", dsp_start, (m_start >= 0) && (cyc == m_start + 1));
        chk("busy", busy, exp_busy);
        chk("frame_out_valid", frame_out_valid, exp_valid);
        chk("overrun", overrun, m_ovr);
        chk("host_wr_ready", host_wr_ready, exp_ready);
        chk("pmem_wr_en", pmem_wr_en, exp_wen);
        chk("dsp_inputs", dsp_inputs, m_inputs);
        chk("frame_out", frame_out, m_frame_out);
`ifdef DSP_FRAME_COUNTER_EN
        chk("frame_count", frame_count, m_count);
`endif
        if (exp_wen) begin
            chk("pmem_wr_addr", pmem_wr_addr, host_wr_addr);
            chk("pmem_wr_data", pmem_wr_data, host_wr_data);
            wr_done = 1'b1;
            $display("cycle %0d: param write addr=%0h data=%0h", cyc, host_wr_addr, host_wr_data);
        end
        if (exp_valid) begin
            frames_seen++;
            $display("cycle %0d: frame %0d out=%0h", cyc, frames_seen, frame_out);
        end
        // Effect of this cycle's inputs at the coming edge
        if (reset) begin
            m_start = -1; m_valid_cyc = -1; m_ovr = 1'b0;
            m_inputs = '0; m_frame_out = '0; m_count = '0;
        end else begin
            if (exp_valid) m_count = m_count + 32'd1;
            if (sample_strobe && exp_busy) m_ovr = 1'b1;
            else if (overrun_clear) m_ovr = 1'b0;
            if (exp_busy && cyc == m_start + 1 + PL + PD) begin
                m_frame_out = dsp_outputs;
                m_valid_cyc = cyc + 1;
            end
            if (!exp_busy && sample_strobe) begin
                m_start  = cyc;
                m_inputs = frame_in;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic strobe_step();
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
    endtask

    task automatic wait_write(input int budget);
        int n = 0;
        while (!wr_done && n < budget) begin
            step();
            n++;
        end
        chk("host_write_accepted", wr_done, 1'b1);
        host_wr_valid = 1'b0;
        wr_done = 1'b0;
    endtask

    initial begin
        int s;
        @(posedge clk);
        #1;
        repeat (3) step();
        reset = 1'b0;
        run_to(5);

        // Single frame with a dropped strobe, overrun clear and a held host write
        s = cyc;
        strobe_step();
        run_to(s + 50);
        host_wr_addr = 8'h12;
        host_wr_data = 36'h123456789;
        host_wr_valid = 1'b1;
        run_to(s + 100);
        strobe_step();
        run_to(s + 200);
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        run_to(s + 519);
        chk("held_write_done", wr_done, 1'b1);
        host_wr_valid = 1'b0;
        wr_done = 1'b0;
        run_to(s + 530);

        // Strobe and host write in the same idle cycle: write deferred past the frame
        host_wr_addr = 8'h5a;
        host_wr_data = DWW'({$urandom(), $urandom()});
        host_wr_valid = 1'b1;
        strobe_step();
        wait_write(1000);
        run_to(cyc + 10);

        // Three back-to-back frames at the minimum period
        s = cyc;
        for (int k = 0; k < 3; k++) begin
            run_to(s + (PL + PD + 2) * k);
            strobe_step();
        end
        run_to(s + 3 * (PL + PD + 2) + 5);

        // Reset in the middle of a frame, then a fresh frame
        s = cyc;
        strobe_step();
        run_to(s + 300);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_to(cyc + 600);
        strobe_step();
        run_to(cyc + 530);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            sample_strobe = ($urandom_range(0, 299) == 0);
            host_wr_valid = ($urandom_range(0, 3) == 0);
            host_wr_addr  = PAW'($urandom());
            host_wr_data  = DWW'({$urandom(), $urandom()});
            overrun_clear = ($urandom_range(0, 99) == 0);
            reset         = ($urandom_range(0, 1999) == 0);
            step();
        end
        sample_strobe = 1'b0;
        host_wr_valid = 1'b0;
        overrun_clear = 1'b0;
        reset = 1'b0;
        run_to(cyc + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/dsp_frame_scheduler.md
DSP_FRAME_SCHEDULER -- requirements
Module: dsp_frame_scheduler

Interface
REQ-001 SHALL have parameter PROGRAM_LEN, default 512: instruction cycles the DSP core needs per frame.
REQ-002 SHALL have parameter PIPE_DEPTH, default 4: drain cycles after the last instruction before outputs are stable.
REQ-003 SHALL have parameter DWW, default 36: sample and parameter word width.
REQ-004 SHALL have parameter PAW, default 8: parameter memory address width.
REQ-005 SHALL use one clock; reset is synchronous and active-high (ports clk, reset).
REQ-006 SHALL have ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sample_strobe  in  1  new input frame present on frame_in
frame_in  in  8 x DWW  audio input samples
dsp_inputs  out  8 x DWW  latched samples driven to the DSP core inputs
dsp_start  out  1  one-cycle start pulse to the DSP core
dsp_outputs  in  8 x DWW  DSP core output samples
frame_out  out  8 x DWW  captured processed frame
frame_out_valid  out  1  one-cycle pulse, frame_out updated
busy  out  1  frame in progress
overrun  out  1  sticky, strobe arrived while busy
overrun_clear  in  1  clears overrun
host_wr_valid  in  1  host parameter write request
host_wr_ready  out  1  host write accepted this cycle
host_wr_addr  in  PAW  parameter address
host_wr_data  in  DWW  parameter value
pmem_wr_en  out  1  parameter memory write enable
pmem_wr_addr  out  PAW  parameter memory write address
pmem_wr_data  out  DWW  parameter memory write data

Function
REQ-007 SHALL implement FSM states IDLE, START, RUN, DRAIN.
REQ-008 IDLE -> START when sample_strobe=1; dsp_inputs <= frame_in on that edge.
REQ-009 START lasts 1 cycle with dsp_start=1; dsp_start=0 in all other states.
REQ-010 RUN lasts exactly PROGRAM_LEN cycles, counted by an internal counter; then DRAIN.
REQ-011 DRAIN lasts exactly PIPE_DEPTH cycles (PIPE_DEPTH=0 skips DRAIN); then IDLE.
REQ-012 On the edge leaving the final RUN/DRAIN cycle, frame_out <= dsp_outputs, and frame_out_valid=1 for the following cycle only.
REQ-013 Latency: strobe in cycle T -> dsp_start in T+1 -> frame_out_valid in T+2+PROGRAM_LEN+PIPE_DEPTH.
REQ-014 busy=1 in START, RUN and DRAIN; busy=0 in IDLE.
REQ-015 A strobe in the IDLE cycle carrying frame_out_valid SHALL be accepted normally (minimum frame period PROGRAM_LEN+PIPE_DEPTH+2).
REQ-016 A strobe while busy=1 SHALL be dropped, SHALL NOT alter dsp_inputs, and SHALL set overrun on the next edge.
REQ-017 overrun_clear clears overrun; a simultaneous set wins over clear.
REQ-018 host_wr_ready = (state==IDLE) && !sample_strobe, combinational; the strobe has priority over host writes.
REQ-019 pmem_wr_en = host_wr_valid && host_wr_ready, with pmem_wr_addr/data passed through combinationally from host_wr_addr/data.
REQ-020 No parameter write SHALL occur while busy=1, so each frame sees one consistent coefficient set.
REQ-021 A host request held while busy SHALL stay pending with no data loss, and SHALL be accepted in the first IDLE cycle without a strobe.

Reset
REQ-022 reset SHALL force IDLE, clear the counter, and drive dsp_start=0, frame_out_valid=0, busy=0, overrun=0, pmem_wr_en=0, dsp_inputs=0, frame_out=0.
REQ-023 Reset mid-frame SHALL abort the frame with no frame_out_valid pulse; the first strobe after reset deasserts starts a fresh frame.

Configuration
REQ-024 Macro DSP_FRAME_COUNTER_EN defined: output frame_count (32 bits) is reset to 0 and increments, with wrap, on each frame_out_valid pulse.
REQ-025 Macro DSP_FRAME_COUNTER_EN undefined: the frame_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-026 PROGRAM_LEN=512, PIPE_DEPTH=4, strobe at cycle 0 -> dsp_start at cycle 1 only, busy cycles 1-517, frame_out_valid at cycle 518 with frame_out equal to dsp_outputs from cycle 517.
REQ-027 Strobe at cycle 0 and again at cycle 100 -> second strobe dropped, overrun=1 from cycle 101, dsp_inputs unchanged; overrun_clear at cycle 200 -> overrun=0 at cycle 201.
REQ-028 host_wr_valid held from cycle 50 (addr 0x12, data 0x123456789) during a frame -> host_wr_ready=0 until cycle 518, then a single pmem_wr_en pulse at cycle 518 with that addr/data.
REQ-029 Strobe and host_wr_valid in the same IDLE cycle -> START entered, host_wr_ready=0, write deferred to the next idle non-strobe cycle.
REQ-030 reset asserted at cycle 300 of a frame -> no frame_out_valid pulse, all outputs at reset values; strobe after reset -> a normal 518-cycle frame.
REQ-031 With DSP_FRAME_COUNTER_EN defined, 3 back-to-back frames at the minimum period (strobes at cycles 0, 518, 1036) -> no overrun, frame_count reads 3.
